// File: rtl/mem_responder_pkg.sv
// Shared CPU definitions: memory-mapped address constants and the
// read-source select used by the memory responder.
package mem_responder_pkg;

  localparam logic [15:0] RAM_TOP  = 16'h03FF;
  localparam logic [15:0] ADDR_LED = 16'hFF00;
  localparam logic [15:0] ADDR_SW  = 16'hFF01;
  localparam logic [15:0] ADDR_BTN = 16'hFF02;
  localparam logic [15:0] ADDR_CNT = 16'hFF03;

  typedef enum logic [2:0] {
    SEL_NONE,
    SEL_RAM,
    SEL_LED,
    SEL_SW,
    SEL_BTN,
    SEL_CNT
  } sel_e;

endpackage

// File: rtl/mem_responder_ram_1p.sv
// Inferred single-port RAM: read-first, synchronous read, no reset.
module ram_1p #(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned ADDR_BITS = 10
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [ADDR_BITS-1:0] addr,
  input  logic [WIDTH-1:0]     wdata,
  output logic [WIDTH-1:0]     rdata
);

  logic [WIDTH-1:0] mem_q [0:(1<<ADDR_BITS)-1];
  logic [WIDTH-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[addr] <= wdata;
    end
    rdata_q <= mem_q[addr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// CPU memory responder: RAM plus LED, switch, sticky-button and cycle-counter
// registers, all with a fixed one-cycle read latency.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned RAM_BITS = 10,
  parameter int unsigned IO_BITS  = 10
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [WIDTH-1:0]   mem_addr,
  input  logic               MEM_WR_S,
  input  logic [WIDTH-1:0]   writedata,
  output logic [WIDTH-1:0]   mem_out,
  input  logic [IO_BITS-1:0] sw,
  input  logic [3:0]         btn,
  output logic [IO_BITS-1:0] leds
);

  sel_e               sel;
  logic               ram_we;
  logic [WIDTH-1:0]   ram_rdata;
  logic               sel_ram_d, sel_ram_q;
  logic [WIDTH-1:0]   io_rd_d, io_rd_q;
  logic [IO_BITS-1:0] led_d, led_q;
  logic [IO_BITS-1:0] sw_meta_q, sw_sync_q;
  logic [3:0]         btn_meta_q, btn_sync_q, btn_dly_q;
  logic [3:0]         press;
  logic [3:0]         sticky_d, sticky_q;
  logic [WIDTH-1:0]   cnt_d, cnt_q;

  always_comb begin
    sel = SEL_NONE;
    if (mem_addr <= WIDTH'(RAM_TOP))        sel = SEL_RAM;
    else if (mem_addr == WIDTH'(ADDR_LED))  sel = SEL_LED;
    else if (mem_addr == WIDTH'(ADDR_SW))   sel = SEL_SW;
    else if (mem_addr == WIDTH'(ADDR_BTN))  sel = SEL_BTN;
    else if (mem_addr == WIDTH'(ADDR_CNT))  sel = SEL_CNT;
  end

  // Gating with reset aborts a write that collides with reset assertion.
  assign ram_we = MEM_WR_S && (sel == SEL_RAM) && reset;

  ram_1p #(
    .WIDTH     (WIDTH),
    .ADDR_BITS (RAM_BITS)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .addr  (mem_addr[RAM_BITS-1:0]),
    .wdata (writedata),
    .rdata (ram_rdata)
  );

  // A press is a synchronized high-to-low transition of an active-low button.
  assign press = btn_dly_q & ~btn_sync_q;

  always_comb begin
    led_d    = led_q;
    sticky_d = sticky_q;
    cnt_d    = cnt_q + WIDTH'(1);
    if (MEM_WR_S && sel == SEL_LED) led_d = writedata[IO_BITS-1:0];
    if (MEM_WR_S && sel == SEL_BTN) sticky_d = sticky_q & ~writedata[3:0];
    if (MEM_WR_S && sel == SEL_CNT) cnt_d = writedata;
    sticky_d = sticky_d | press;
  end

  always_comb begin
    io_rd_d   = '0;
    sel_ram_d = (sel == SEL_RAM);
    case (sel)
      SEL_LED: io_rd_d[IO_BITS-1:0] = led_q;
      SEL_SW:  io_rd_d[IO_BITS-1:0] = sw_sync_q;
      SEL_BTN: io_rd_d[3:0]         = sticky_q;
      SEL_CNT: io_rd_d              = cnt_q;
      default: io_rd_d              = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sel_ram_q  <= 1'b0;
      io_rd_q    <= '0;
      led_q      <= '0;
      sw_meta_q  <= '0;
      sw_sync_q  <= '0;
      btn_meta_q <= '1;
      btn_sync_q <= '1;
      btn_dly_q  <= '1;
      sticky_q   <= '0;
      cnt_q      <= '0;
    end else begin
      sel_ram_q  <= sel_ram_d;
      io_rd_q    <= io_rd_d;
      led_q      <= led_d;
      sw_meta_q  <= sw;
      sw_sync_q  <= sw_meta_q;
      btn_meta_q <= btn;
      btn_sync_q <= btn_meta_q;
      btn_dly_q  <= btn_sync_q;
      sticky_q   <= sticky_d;
      cnt_q      <= cnt_d;
    end
  end

  // RAM data is already registered inside ram_1p; select it after the fact.
  assign mem_out = sel_ram_q ? ram_rdata : io_rd_q;
  assign leds    = led_q;

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder against a behavioural address-map model.
module tb_mem_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] mem_addr, writedata, mem_out;
  logic        MEM_WR_S;
  logic [9:0]  sw, leds;
  logic [3:0]  btn;

  int total = 0;
  int bad   = 0;

  logic [15:0] ram_m [1024];
  logic [9:0]  led_m;
  logic [3:0]  sticky_m, press_m;
  logic [15:0] cnt_m;
  logic [9:0]  sw_old_m;
  int          sw_age;
  logic [15:0] exp_out;

  mem_responder #(.WIDTH(16), .RAM_BITS(10), .IO_BITS(10)) dut (
    .clk(clk), .reset(reset), .mem_addr(mem_addr), .MEM_WR_S(MEM_WR_S),
    .writedata(writedata), .mem_out(mem_out), .sw(sw), .btn(btn), .leds(leds)
  );

  always #10 clk = ~clk;

  task automatic model_reset();
    led_m = '0; sticky_m = '0; press_m = '0; cnt_m = '0; sw_old_m = '0; sw_age = 0;
  endtask

  task automatic set_sw(input logic [9:0] v);
    sw_old_m = (sw_age >= 2) ? sw : sw_old_m;
    sw = v;
    sw_age = 0;
  endtask

  // Predict the read result of the coming edge, apply the edge to the model, advance.
  task automatic tick();
    if (mem_addr <= 16'h03FF) exp_out = ram_m[mem_addr[9:0]];
    else case (mem_addr)
      16'hFF00: exp_out = {6'b0, led_m};
      16'hFF01: exp_out = {6'b0, (sw_age >= 2) ? sw : sw_old_m};
      16'hFF02: exp_out = {12'b0, sticky_m};
      16'hFF03: exp_out = cnt_m;
      default:  exp_out = 16'h0000;
    endcase
    if (MEM_WR_S) begin
      if (mem_addr <= 16'h03FF)      ram_m[mem_addr[9:0]] = writedata;
      else if (mem_addr == 16'hFF00) led_m = writedata[9:0];
      else if (mem_addr == 16'hFF02) sticky_m = sticky_m & ~writedata[3:0];
    end
    cnt_m = (MEM_WR_S && mem_addr == 16'hFF03) ? writedata : cnt_m + 16'd1;
    sticky_m = sticky_m | press_m;
    press_m = '0;
    if (sw_age < 2) sw_age++;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; mem_addr = '0; MEM_WR_S = 1'b0; writedata = '0; sw = '0; btn = 4'hF;
    model_reset();
    #5;
    total++; if (mem_out !== 16'h0000) begin bad++; $display("FAIL reset_mem_out: got %h want 0000", mem_out); end
    total++; if (leds !== 10'h000) begin bad++; $display("FAIL reset_leds: got %h want 000", leds); end
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    model_reset();
  endtask

  task automatic test_ram();
    for (int unsigned i = 0; i < 64; i++) begin
      mem_addr = 16'(i); MEM_WR_S = 1'b1; writedata = 16'($urandom); tick();
    end
    mem_addr = 16'h0010; writedata = 16'hBEEF; tick();
    MEM_WR_S = 1'b0; tick();
    total++; if (mem_out !== 16'hBEEF) begin bad++; $display("FAIL ram_roundtrip: got %h want beef", mem_out); end
    MEM_WR_S = 1'b1; writedata = 16'h1234; tick();
    total++; if (mem_out !== 16'hBEEF) begin bad++; $display("FAIL ram_read_first: got %h want beef", mem_out); end
    MEM_WR_S = 1'b0; tick();
    total++; if (mem_out !== 16'h1234) begin bad++; $display("FAIL ram_new_word: got %h want 1234", mem_out); end
    for (int unsigned i = 0; i < 20; i++) begin
      mem_addr = 16'($urandom_range(0, 63)); tick();
      total++; if (mem_out !== exp_out) begin bad++; $display("FAIL ram_rand_read @%h: got %h want %h", mem_addr, mem_out, exp_out); end
    end
  endtask

  task automatic test_io();
    mem_addr = 16'hFF00; MEM_WR_S = 1'b1; writedata = 16'h03FF; tick();
    total++; if (leds !== 10'h3FF) begin bad++; $display("FAIL led_write: got %h want 3ff", leds); end
    MEM_WR_S = 1'b0; tick();
    total++; if (mem_out !== 16'h03FF) begin bad++; $display("FAIL led_readback: got %h want 03ff", mem_out); end
    set_sw(10'h155);
    mem_addr = 16'hFF01;
    repeat (3) tick();
    total++; if (mem_out !== 16'h0155 || exp_out !== 16'h0155) begin bad++; $display("FAIL sw_sync: got %h want 0155", mem_out); end
  endtask

  task automatic test_unmapped();
    MEM_WR_S = 1'b1; writedata = 16'hAAAA;
    mem_addr = 16'h0400; tick();
    mem_addr = 16'hFF01; tick();
    MEM_WR_S = 1'b0;
    mem_addr = 16'h0400; tick();
    total++; if (mem_out !== 16'h0000) begin bad++; $display("FAIL unmapped_read: got %h want 0000", mem_out); end
    mem_addr = 16'hFF01; tick();
    total++; if (mem_out !== 16'h0155) begin bad++; $display("FAIL sw_readonly: got %h want 0155", mem_out); end
    mem_addr = 16'h0000; tick();
    total++; if (mem_out !== exp_out) begin bad++; $display("FAIL unmapped_alias: got %h want %h", mem_out, exp_out); end
  endtask

  task automatic test_buttons();
    mem_addr = 16'hFF02; MEM_WR_S = 1'b0;
    btn = 4'b1011;
    tick(); tick();
    press_m = 4'b0100;
    tick(); tick(); tick();
    btn = 4'hF;
    repeat (4) tick();
    for (int unsigned i = 0; i < 3; i++) begin
      tick();
      total++; if (mem_out !== 16'h0004) begin bad++; $display("FAIL btn_sticky_read%0d: got %h want 0004", i, mem_out); end
    end
    btn = 4'b1011;
    tick(); tick();
    MEM_WR_S = 1'b1; writedata = 16'h0004; press_m = 4'b0100; tick();
    MEM_WR_S = 1'b0; tick();
    total++; if (mem_out !== 16'h0004) begin bad++; $display("FAIL btn_set_wins: got %h want 0004", mem_out); end
    btn = 4'hF;
    repeat (3) tick();
    MEM_WR_S = 1'b1; writedata = 16'h0004; tick();
    MEM_WR_S = 1'b0; tick();
    total++; if (mem_out !== 16'h0000) begin bad++; $display("FAIL btn_clear: got %h want 0000", mem_out); end
  endtask

  task automatic test_counter();
    logic [15:0] want [4];
    want = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};
    mem_addr = 16'hFF03; MEM_WR_S = 1'b1; writedata = 16'hFFFE; tick();
    MEM_WR_S = 1'b0;
    for (int unsigned i = 0; i < 4; i++) begin
      tick();
      total++; if (mem_out !== want[i]) begin bad++; $display("FAIL cnt_wrap%0d: got %h want %h", i, mem_out, want[i]); end
    end
  endtask

  task automatic test_random();
    int unsigned kind;
    for (int unsigned n = 0; n < 300; n++) begin
      kind = $urandom_range(0, 9);
      if (kind <= 4)      mem_addr = 16'($urandom_range(0, 63));
      else if (kind == 5) mem_addr = 16'hFF00;
      else if (kind == 6) mem_addr = 16'hFF01;
      else if (kind == 7) mem_addr = 16'hFF02;
      else if (kind == 8) mem_addr = 16'hFF03;
      else mem_addr = $urandom_range(0, 1) ? 16'($urandom_range(16'h0400, 16'hFEFF))
                                           : 16'($urandom_range(16'hFF04, 16'hFFFF));
      MEM_WR_S = 1'($urandom_range(0, 1));
      writedata = 16'($urandom);
      tick();
      total++; if (mem_out !== exp_out) begin bad++; $display("FAIL rand_read @%h: got %h want %h", mem_addr, mem_out, exp_out); end
      total++; if (leds !== led_m) begin bad++; $display("FAIL rand_leds: got %h want %h", leds, led_m); end
    end
    MEM_WR_S = 1'b0;
  endtask

  task automatic test_async_reset();
    mem_addr = 16'h0010; MEM_WR_S = 1'b1; writedata = 16'h5A5A; tick();
    mem_addr = 16'hFF00; writedata = 16'h03FF; tick();
    MEM_WR_S = 1'b0; mem_addr = 16'hFF02;
    btn = 4'h0;
    tick(); tick();
    press_m = 4'hF;
    tick(); tick();
    btn = 4'hF;
    repeat (3) tick();
    total++; if (mem_out !== 16'h000F) begin bad++; $display("FAIL pre_reset_sticky: got %h want 000f", mem_out); end
    mem_addr = 16'h0010; tick();
    total++; if (mem_out !== 16'h5A5A || leds !== 10'h3FF) begin bad++; $display("FAIL pre_reset_state: got %h/%h want 5a5a/3ff", mem_out, leds); end
    #3 reset = 1'b0;
    #1;
    total++; if (leds !== 10'h000) begin bad++; $display("FAIL async_reset_leds: got %h want 000", leds); end
    total++; if (mem_out !== 16'h0000) begin bad++; $display("FAIL async_reset_mem_out: got %h want 0000", mem_out); end
    @(posedge clk); #1;
    reset = 1'b1;
    model_reset();
    tick();
    total++; if (mem_out !== 16'h5A5A) begin bad++; $display("FAIL ram_survives_reset: got %h want 5a5a", mem_out); end
    mem_addr = 16'hFF02;
    repeat (4) tick();
    total++; if (mem_out !== 16'h0000) begin bad++; $display("FAIL no_press_after_reset: got %h want 0000", mem_out); end
    mem_addr = 16'hFF03; tick();
    total++; if (mem_out !== exp_out) begin bad++; $display("FAIL cnt_after_reset: got %h want %h", mem_out, exp_out); end
    total++; if (leds !== 10'h000) begin bad++; $display("FAIL leds_after_reset: got %h want 000", leds); end
  endtask

  initial begin
    test_reset();
    test_ram();
    test_io();
    test_unmapped();
    test_buttons();
    test_counter();
    test_random();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
